// File: rtl/pio_clkdiv.sv
// Fractional clock-enable generator for the PIO state machines.
// Each SM gets an independent divider: a 17-bit down-counter that is
// reloaded with INT_eff (+1 on accumulator carry) every pulse, and an
// 8-bit fraction accumulator that spreads FRAC/256 across periods.
// The output pulse is registered and one clk cycle wide.
module pio_clkdiv #(
  parameter int NUM_SM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*NUM_SM-1:0]  clkdiv_in,
  input  logic [NUM_SM-1:0]     sm_en,
  input  logic [NUM_SM-1:0]     clkdiv_restart,
  output logic [NUM_SM-1:0]     clk_en
);

  genvar g;
  generate
    for (g = 0; g < NUM_SM; g++) begin : g_sm
      logic [16:0] rem_q, rem_d;
      logic [7:0]  acc_q, acc_d;
      logic        en_q,  en_d;

      logic [15:0] int_f;
      logic [7:0]  frac_f;
      logic [16:0] int_eff;
      logic [7:0]  frac_eff;
      logic [8:0]  sum;
      logic        unused_low;

      assign int_f      = clkdiv_in[32*g+16 +: 16];
      assign frac_f     = clkdiv_in[32*g+8  +: 8];
      // Low byte of each CLKDIV image carries no divider information.
      assign unused_low = ^clkdiv_in[32*g +: 8];

      // Next-state: restart beats enable; disabled SMs hold their count;
      // enabled SMs either reload (pulse) at rem==1 or count down.
      always_comb begin
        int_eff  = (int_f == 16'd0) ? 17'h10000 : {1'b0, int_f};
        frac_eff = (int_f == 16'd0) ? 8'd0 : frac_f;
        sum      = {1'b0, acc_q} + {1'b0, frac_eff};
        rem_d    = rem_q;
        acc_d    = acc_q;
        en_d     = 1'b0;
        if (clkdiv_restart[g]) begin
          rem_d = 17'd1;
          acc_d = 8'd0;
        end else if (sm_en[g]) begin
          if (rem_q == 17'd1) begin
            en_d  = 1'b1;
            acc_d = sum[7:0];
            rem_d = int_eff + {16'd0, sum[8]};
          end else begin
            rem_d = rem_q - 17'd1;
          end
        end
      end

      // Divider state registers with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          rem_q <= 17'd1;
          acc_q <= 8'd0;
          en_q  <= 1'b0;
        end else begin
          rem_q <= rem_d;
          acc_q <= acc_d;
          en_q  <= en_d;
        end
      end

      assign clk_en[g] = en_q;
    end
  endgenerate

endmodule

// File: tb/tb_pio_clkdiv.sv
// Directed testbench for pio_clkdiv. Inputs are driven on the falling edge,
// outputs are checked on the falling edge after each rising edge.
// Loop index c denotes the rising edge being driven; the check that follows
// looks at cycle c+1 (the cycle after that edge).
module tb_pio_clkdiv;
  localparam int NUM_SM = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [32*NUM_SM-1:0] clkdiv_in;
  logic [NUM_SM-1:0]    sm_en;
  logic [NUM_SM-1:0]    clkdiv_restart;
  logic [NUM_SM-1:0]    clk_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_clkdiv #(.NUM_SM(NUM_SM)) dut (
    .clk            (clk),
    .rst            (rst),
    .clkdiv_in      (clkdiv_in),
    .sm_en          (sm_en),
    .clkdiv_restart (clkdiv_restart),
    .clk_en         (clk_en)
  );

  function automatic logic [31:0] img(input logic [15:0] int_v,
                                      input logic [7:0] frac_v,
                                      input logic [7:0] low_v);
    return {int_v, frac_v, low_v};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst            = 1'b1;
    sm_en          = 4'b0000;
    clkdiv_restart = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    logic [3:0] exp;

    rst            = 1'b1;
    sm_en          = 4'b0000;
    clkdiv_restart = 4'b0000;
    clkdiv_in      = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("reset", clk_en, 4'b0000);

    // D = 1.0 on SM0: continuous pulse from cycle 1; others idle
    clkdiv_in = {img(16'd3, 8'h00, 8'h00), img(16'd3, 8'h00, 8'h00),
                 img(16'd3, 8'h00, 8'h00), img(16'd1, 8'h00, 8'h00)};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      sm_en = 4'b0001;
      tick();
      check($sformatf("div1_c%0d", c + 1), clk_en, 4'b0001);
    end

    // INT=3, low byte non-zero (ignored): pulses at 1,4,7,10
    clkdiv_in[31:0] = img(16'd3, 8'h00, 8'hFF);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      sm_en = 4'b0001;
      tick();
      n = c + 1;
      exp = (n == 1 || n == 4 || n == 7 || n == 10) ? 4'b0001 : 4'b0000;
      check($sformatf("div3_c%0d", n), clk_en, exp);
    end

    // INT=2 FRAC=0x80: pulses at 1,3,6,8,11
    clkdiv_in[31:0] = img(16'd2, 8'h80, 8'h00);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      sm_en = 4'b0001;
      tick();
      n = c + 1;
      exp = (n == 1 || n == 3 || n == 6 || n == 8 || n == 11) ? 4'b0001 : 4'b0000;
      check($sformatf("div2p5_c%0d", n), clk_en, exp);
    end

    // INT=0 FRAC=0xFF: pulses at 1 and 65537 only
    clkdiv_in[31:0] = img(16'd0, 8'hFF, 8'h00);
    do_reset();
    sm_en = 4'b0001;
    tick();
    check("int0_first", clk_en, 4'b0001);
    pulses = 0;
    for (int c = 2; c <= 65536; c++) begin
      tick();
      if (clk_en[0]) pulses++;
    end
    checks++;
    assert (pulses == 0) else begin
      failures++;
      $error("FAIL int0_gap observed=%0d expected=0", pulses);
    end
    tick();
    check("int0_second", clk_en, 4'b0001);

    // INT=5 pause: 2 enabled edges, 10 disabled, pulse after 3 more
    clkdiv_in[31:0] = img(16'd5, 8'h00, 8'h00);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      sm_en = (c >= 3 && c <= 12) ? 4'b0000 : 4'b0001;
      tick();
      n = c + 1;
      exp = (n == 1 || n == 16) ? 4'b0001 : 4'b0000;
      check($sformatf("pause_c%0d", n), clk_en, exp);
    end

    // Restart aligns SM1 and SM2 that started with different phases
    clkdiv_in = {img(16'd3, 8'h00, 8'h00), img(16'd4, 8'h00, 8'h00),
                 img(16'd4, 8'h00, 8'h00), img(16'd3, 8'h00, 8'h00)};
    do_reset();
    for (int c = 0; c < 16; c++) begin
      sm_en          = {1'b0, (c >= 2), 1'b1, 1'b0};
      clkdiv_restart = (c == 5) ? 4'b0110 : 4'b0000;
      tick();
      n = c + 1;
      exp = 4'b0000;
      exp[1] = (n == 1 || n == 5 || n == 7 || n == 11 || n == 15);
      exp[2] = (n == 3 || n == 7 || n == 11 || n == 15);
      check($sformatf("restart_c%0d", n), clk_en, exp);
    end
    clkdiv_restart = 4'b0000;

    // Reset mid-period with all SMs enabled
    clkdiv_in = {img(16'd3, 8'h40, 8'h00), img(16'd3, 8'h30, 8'h00),
                 img(16'd3, 8'h20, 8'h00), img(16'd3, 8'h10, 8'h00)};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      sm_en = 4'b1111;
      rst   = (c == 6);
      tick();
      n = c + 1;
      exp = (n == 1 || n == 4 || n == 8) ? 4'b1111 : 4'b0000;
      check($sformatf("midrst_c%0d", n), clk_en, exp);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pio_clkdiv.md
# pio_clkdiv

Fractional clock-enable generator for the PIO block's four state machines. It consumes each SM's CLKDIV register image and the CTRL fields `SM_ENABLE` and `CLKDIV_RESTART` from the control register file. It produces one single-cycle clock-enable pulse per SM; the SM execution core advances exactly one instruction step on each pulse. The effective divisor is INT + FRAC/256, realised by a first-order accumulator.

## Interface
Parameters:
- `NUM_SM`, default 4: number of state machines; one divider per SM.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous and active-high.
- `clkdiv_in`  in  32*NUM_SM  CLKDIV images; SM i occupies bits [32i+31:32i]. Within each image, INT is [31:16] and FRAC is [15:8]. Bits [7:0] are ignored.
- `sm_en`  in  NUM_SM  per-SM enable (CTRL[3:0]).
- `clkdiv_restart`  in  NUM_SM  per-SM restart strobe (CTRL[11:8]), single-cycle.
- `clk_en`  out  NUM_SM  per-SM step pulse, registered.

## Operation
- Each SM has its own state:
  - `rem`: 17-bit down-counter.
  - `acc`: 8-bit fraction accumulator.
  - `clk_en[i]`: output register.
- Effective integer divisor: INT_eff = 65536 when INT == 0, otherwise INT_eff = INT.
  - When INT == 0, FRAC is treated as 0.
- Per-SM update on each rising edge of `clk`, evaluated in priority order:
  1. `rst`: rem <= 1, acc <= 0, clk_en <= 0. This applies to all SMs.
  2. `clkdiv_restart[i]`: rem <= 1, acc <= 0, clk_en[i] <= 0. Restart overrides `sm_en[i]`.
  3. `sm_en[i]` == 0: clk_en[i] <= 0; rem and acc hold their values (pause).
  4. `sm_en[i]` == 1 and rem == 1 (reload):
     - clk_en[i] <= 1.
     - {carry, acc} <= acc + FRAC, as a 9-bit sum.
     - rem <= INT_eff + carry.
  5. `sm_en[i]` == 1 and rem != 1: clk_en[i] <= 0; rem <= rem - 1.
- INT and FRAC are sampled only at reload. A CLKDIV write mid-period takes effect in the period that starts at the next pulse.
- Sequence property: for divisor D = INT + FRAC/256, every N consecutive pulse intervals sum to floor(N·D) or ceil(N·D). Each individual interval is INT_eff or INT_eff+1 cycles.
- Width rule: rem never exceeds 65537, so 17 bits suffice.
- The SMs are fully independent. Simultaneous restarts on several SMs align their phases exactly.

## Timing
- Reset values: `clk_en` = 0 for all SMs; rem = 1; acc = 0.
- Latency from enable: if `sm_en[i]` rises and is sampled at edge k (with rem == 1), `clk_en[i]` is high in the cycle after edge k. The first step pulse therefore lags enable by one cycle.
- Pulse width: exactly one `clk` cycle. The pulse is continuous (high every cycle) only when D == 1.0, i.e. INT=1 and FRAC=0.
- Interval definition: the distance between rising edges of consecutive pulses equals rem as loaded at the earlier pulse.
- Pause and resume: deasserting `sm_en` at edge k forces `clk_en` low after edge k. Reasserting at edge m continues counting from the held rem, so the total enabled cycles per interval is preserved.
- Restart while enabled: the first pulse comes one cycle after the restart edge. The restart cycle itself yields clk_en = 0.
- Restart and reset mid-period discard the partial count and the fraction.
- A reload coinciding with `sm_en` deassertion does not happen; the disable takes priority and rem stays 1.

## Test plan
- INT=1, FRAC=0, sm_en=4'b0001 from cycle 0 -> clk_en[0] is high continuously from cycle 1; the other SMs stay 0.
- INT=3, FRAC=0 -> pulses at cycles 1, 4, 7, 10, which is every 3 cycles.
- INT=2, FRAC=0x80 -> pulses at cycles 1, 3, 6, 8, 11 (intervals 2, 3, 2, 3), giving an average divisor of 2.5. acc sequence: 0x80, 0x00, 0x80, 0x00.
- INT=0, FRAC=0xFF -> pulses at cycle 1 and cycle 65537; FRAC has no effect.
- INT=5, sm_en dropped for 10 cycles after 2 enabled cycles of an interval -> the next pulse follows after 3 further enabled cycles. `clkdiv_restart` pulsed mid-interval on SM1 and SM2 with different prior phases -> both pulse on the same cycle one cycle later and stay aligned.
- `rst` asserted mid-period with sm_en held at 4'b1111 -> all `clk_en` outputs are 0 in the cycle after the reset edge. After `rst` falls, every SM pulses on the first enabled edge's following cycle.
